ans_symbol_packer: RTL
======================

Name: ans_symbol_packer

Overview:
- Sits directly downstream of ans_decoder and consumes its decoded symbol stream through the same valid/ready pair.
- Packs SYM_WIDTH-bit symbols LSB-first into OUT_WIDTH-bit words for the 8-bit chip output bus.
- A flush request pushes out any partial word, zero-padded and tagged last, so a decode run ends on a word boundary.

Parameters:
- SYM_WIDTH, default 4: symbol width in bits; legal range 1..OUT_WIDTH; normally driven from `SYM_WIDTH.
- OUT_WIDTH, default 8: packed output word width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in  in  SYM_WIDTH  symbol from ans_decoder out.
- in_vld  in  1  symbol valid.
- in_rdy  out  1  packer can accept a symbol.
- flush  in  1  single-cycle flush request.
- out  out  OUT_WIDTH  packed word.
- out_vld  out  1  word valid.
- out_rdy  in  1  downstream accepts word.
- out_last  out  1  qualifies out; high only on the zero-padded flush word.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Internal state:
  - acc: OUT_WIDTH+SYM_WIDTH-1 bits.
  - cnt: number of valid bits in acc, range 0..OUT_WIDTH+SYM_WIDTH-1.
  - flush_pend: 1 bit.
- Reset (rst high at an edge): acc=0, cnt=0, flush_pend=0, out=0, out_vld=0, out_last=0, flush_done=0. This applies mid-operation and discards buffered bits and the held word.
- in_rdy is combinational: !rst && !flush_pend && cnt<OUT_WIDTH. It does not depend on in_vld or on the flush input.
- Accept (in_vld && in_rdy):
  - acc |= in << cnt
  - cnt += SYM_WIDTH
- Output slot is free when !out_vld || out_rdy. A load and a drain may occur in the same cycle, giving full throughput.
- Emit full word (cnt>=OUT_WIDTH and slot free):
  - out <= acc[OUT_WIDTH-1:0], out_vld <= 1, out_last <= 0
  - acc >>= OUT_WIDTH, cnt -= OUT_WIDTH
- Accept and full-word emit are mutually exclusive by construction, since accept requires cnt<OUT_WIDTH and emit requires cnt>=OUT_WIDTH.
- Drain: if out_vld && out_rdy and no load occurs that cycle, out_vld <= 0 and out_last <= 0. out holds its value while out_vld && !out_rdy.
- Latency: the symbol that completes a word is accepted at edge N; the word is presented with out_vld=1 after edge N+1, given a free slot.
- Flush request:
  - flush high at an edge sets flush_pend.
  - flush while flush_pend is already set is ignored.
  - A symbol accepted in the same cycle as flush is included in the flush, because in_rdy uses the registered flush_pend.
- Flush service, while flush_pend=1:
  - Full words drain first, using the normal emit rule.
  - Then, if 0<cnt<OUT_WIDTH and the slot is free: out <= acc[OUT_WIDTH-1:0] with bits at positions >=cnt forced to 0, out_vld=1, out_last=1, acc=0, cnt=0, flush_pend=0, flush_done pulses 1 in the following cycle.
  - If cnt==0: flush_pend=0 and flush_done pulses; no word is produced.
- flush_done is registered: high exactly one cycle and low otherwise.
- Arithmetic: cnt never exceeds OUT_WIDTH+SYM_WIDTH-1 and never underflows. acc bits at positions >=cnt are always 0.

Test Plan:
- SYM_WIDTH=4, out_rdy=1, symbols 0x3 then 0xA -> one word 0xA3, out_vld high one cycle, out_last=0; in_rdy stays high apart from the single emit cycle.
- SYM_WIDTH=3, symbols 1, 2, 7, then flush pulse -> words 0xD1 (out_last=0), then 0x01 (out_last=1); flush_done pulses once after 0x01 is loaded.
- Backpressure, SYM_WIDTH=4, out_rdy=0, symbols 0x1, 0x2, 0x3, 0x4:
  - Expect out=0x21 held stable with out_vld=1, cnt=8, in_rdy=0.
  - Raise out_rdy -> 0x21 then 0x43 on consecutive cycles; in_rdy returns high.
- Flush with cnt==0 (after exactly 0xA3 emitted) -> no extra word, flush_done one-cycle pulse, in_rdy low only while flush_pend is set.
- Flush in the same cycle as an accepted symbol 0x5 with cnt=0, SYM_WIDTH=4 -> padded word 0x05 with out_last=1; a second flush pulse while pending produces no second flush_done.
- rst asserted with out_vld=1 and cnt=4 -> next cycle out=0, out_vld=0, in_rdy=1 after rst drops; a subsequent 0x3, 0xA yields 0xA3 with no stale bits.

Source files
------------

// File: rtl/ans_symbol_packer.sv
// Packs SYM_WIDTH-bit decoded symbols LSB-first into OUT_WIDTH-bit output words.
// A flush pushes out any partial word zero-padded and tagged last, then pulses flush_done.
module ans_symbol_packer #(
    parameter int unsigned SYM_WIDTH = 4,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYM_WIDTH-1:0] in,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_last,
    output logic                 flush_done
);

    localparam int unsigned ACC_W = OUT_WIDTH + SYM_WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] SYM_CNT = CNT_W'(SYM_WIDTH);

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 out_vld_q, out_vld_d;
    logic                 out_last_q, out_last_d;
    logic                 flush_done_q, flush_done_d;

    logic                 accept;
    logic                 slot_free;
    logic                 emit_full;
    logic                 flush_word;
    logic                 flush_empty;
    logic [OUT_WIDTH-1:0] low_word;
    logic [OUT_WIDTH-1:0] pad_mask;

    assign out        = out_q;
    assign out_vld    = out_vld_q;
    assign out_last   = out_last_q;
    assign flush_done = flush_done_q;

    // Handshake decode and next-state for accumulator, output slot and flush tracking.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        out_d        = out_q;
        out_vld_d    = out_vld_q;
        out_last_d   = out_last_q;
        flush_done_d = 1'b0;

        in_rdy      = !rst && !flush_pend_q && (cnt_q < OUT_CNT);
        accept      = in_vld && in_rdy;
        slot_free   = !out_vld_q || out_rdy;
        emit_full   = (cnt_q >= OUT_CNT) && slot_free;
        flush_word  = flush_pend_q && (cnt_q != '0) && (cnt_q < OUT_CNT) && slot_free;
        flush_empty = flush_pend_q && (cnt_q == '0);
        low_word    = acc_q[OUT_WIDTH-1:0];
        pad_mask    = ~({OUT_WIDTH{1'b1}} << cnt_q);

        if (out_vld_q && out_rdy) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end

        // Accept needs cnt<OUT_WIDTH and full emit needs cnt>=OUT_WIDTH, so they never collide.
        if (accept) begin
            acc_d = acc_q | (ACC_W'(in) << cnt_q);
            cnt_d = cnt_q + SYM_CNT;
        end

        if (emit_full) begin
            out_d      = low_word;
            out_vld_d  = 1'b1;
            out_last_d = 1'b0;
            acc_d      = acc_q >> OUT_WIDTH;
            cnt_d      = cnt_q - OUT_CNT;
        end else if (flush_word) begin
            out_d        = low_word & pad_mask;
            out_vld_d    = 1'b1;
            out_last_d   = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
        end else if (flush_empty) begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
        end

        // A repeated request while one is pending is absorbed by the pending one.
        if (flush && !flush_pend_q) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule
